// File: rtl/etapa_ex_mem_ctl_if.sv
// EX/MEM pipeline register bus: EX-stage data, M/WB control and
// hazard/debug controls in, registered MEM-stage copies out.
interface etapa_ex_mem_ctl_if #(
  parameter int NBITS = 32,
  parameter int REGS  = 5,
  parameter int FILTW = 2,
  parameter int CNTW  = 32
);
  logic             i_Enable;
  logic             i_Stall;
  logic             i_Flush;
  logic             i_ClearCount;
  logic             i_Valid;
  logic [NBITS-1:0] i_PC4;
  logic [NBITS-1:0] i_PCBranch;
  logic [NBITS-1:0] i_Instruction;
  logic [NBITS-1:0] i_ALU;
  logic [NBITS-1:0] i_Registro2;
  logic             i_Cero;
  logic [REGS-1:0]  i_RegistroDestino;
  logic             i_Branch;
  logic             i_MemWrite;
  logic             i_MemRead;
  logic             i_MemToReg;
  logic             i_RegWrite;
  logic [FILTW-1:0] i_TamanoFiltro;

  logic [NBITS-1:0] o_PC4;
  logic [NBITS-1:0] o_PCBranch;
  logic [NBITS-1:0] o_Instruction;
  logic [NBITS-1:0] o_ALU;
  logic [NBITS-1:0] o_Registro2;
  logic             o_Cero;
  logic [REGS-1:0]  o_RegistroDestino;
  logic             o_Branch;
  logic             o_MemWrite;
  logic             o_MemRead;
  logic [FILTW-1:0] o_TamanoFiltro;
  logic             o_MemToReg;
  logic             o_RegWrite;
  logic             o_Valid;
  logic             o_PCSrc;
  logic [CNTW-1:0]  o_InstrCount;

  modport master (
    output i_Enable, i_Stall, i_Flush, i_ClearCount, i_Valid,
           i_PC4, i_PCBranch, i_Instruction, i_ALU, i_Registro2, i_Cero,
           i_RegistroDestino, i_Branch, i_MemWrite, i_MemRead, i_MemToReg,
           i_RegWrite, i_TamanoFiltro,
    input  o_PC4, o_PCBranch, o_Instruction, o_ALU, o_Registro2, o_Cero,
           o_RegistroDestino, o_Branch, o_MemWrite, o_MemRead, o_TamanoFiltro,
           o_MemToReg, o_RegWrite, o_Valid, o_PCSrc, o_InstrCount
  );

  modport slave (
    input  i_Enable, i_Stall, i_Flush, i_ClearCount, i_Valid,
           i_PC4, i_PCBranch, i_Instruction, i_ALU, i_Registro2, i_Cero,
           i_RegistroDestino, i_Branch, i_MemWrite, i_MemRead, i_MemToReg,
           i_RegWrite, i_TamanoFiltro,
    output o_PC4, o_PCBranch, o_Instruction, o_ALU, o_Registro2, o_Cero,
           o_RegistroDestino, o_Branch, o_MemWrite, o_MemRead, o_TamanoFiltro,
           o_MemToReg, o_RegWrite, o_Valid, o_PCSrc, o_InstrCount
  );
endinterface

// File: rtl/etapa_ex_mem_ctl.sv
// EX/MEM pipeline register: falling-edge update with priority
// reset > flush > hold > load, bubble-safe control bits, registered
// branch decision and a retired-instruction counter for debug.
module etapa_ex_mem_ctl #(
  parameter int NBITS = 32,
  parameter int REGS  = 5,
  parameter int FILTW = 2,
  parameter int CNTW  = 32
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  etapa_ex_mem_ctl_if.slave    bus
);

  logic [NBITS-1:0] pc4_q,   pc4_d;
  logic [NBITS-1:0] pcbr_q,  pcbr_d;
  logic [NBITS-1:0] instr_q, instr_d;
  logic [NBITS-1:0] alu_q,   alu_d;
  logic [NBITS-1:0] reg2_q,  reg2_d;
  logic             cero_q,  cero_d;
  logic [REGS-1:0]  rd_q,    rd_d;
  logic             br_q,    br_d;
  logic             memw_q,  memw_d;
  logic             memr_q,  memr_d;
  logic [FILTW-1:0] filt_q,  filt_d;
  logic             m2r_q,   m2r_d;
  logic             regw_q,  regw_d;
  logic             valid_q, valid_d;
  logic [CNTW-1:0]  cnt_q,   cnt_d;

  logic load;
  assign load = !bus.i_Flush && !bus.i_Stall && bus.i_Enable;

  // Next-state selection: flush clears the slot, hold keeps it, load copies EX.
  always_comb begin
    pc4_d   = pc4_q;
    pcbr_d  = pcbr_q;
    instr_d = instr_q;
    alu_d   = alu_q;
    reg2_d  = reg2_q;
    cero_d  = cero_q;
    rd_d    = rd_q;
    br_d    = br_q;
    memw_d  = memw_q;
    memr_d  = memr_q;
    filt_d  = filt_q;
    m2r_d   = m2r_q;
    regw_d  = regw_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;

    if (bus.i_Flush) begin
      pc4_d   = '0;
      pcbr_d  = '0;
      instr_d = '0;
      alu_d   = '0;
      reg2_d  = '0;
      cero_d  = 1'b0;
      rd_d    = '0;
      br_d    = 1'b0;
      memw_d  = 1'b0;
      memr_d  = 1'b0;
      filt_d  = '0;
      m2r_d   = 1'b0;
      regw_d  = 1'b0;
      valid_d = 1'b0;
    end else if (load) begin
      pc4_d   = bus.i_PC4;
      pcbr_d  = bus.i_PCBranch;
      instr_d = bus.i_Instruction;
      alu_d   = bus.i_ALU;
      reg2_d  = bus.i_Registro2;
      cero_d  = bus.i_Cero;
      rd_d    = bus.i_RegistroDestino;
      filt_d  = bus.i_TamanoFiltro;
      // A bubble must never write memory or the register file.
      br_d    = bus.i_Branch   & bus.i_Valid;
      memw_d  = bus.i_MemWrite & bus.i_Valid;
      memr_d  = bus.i_MemRead  & bus.i_Valid;
      m2r_d   = bus.i_MemToReg & bus.i_Valid;
      regw_d  = bus.i_RegWrite & bus.i_Valid;
      valid_d = bus.i_Valid;
    end

    if (bus.i_ClearCount) begin
      cnt_d = '0;
    end else if (load && bus.i_Valid) begin
      cnt_d = cnt_q + CNTW'(1);
    end
  end

  // Pipeline state register, falling edge, asynchronous active-low reset.
  always_ff @(negedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      pc4_q   <= '0;
      pcbr_q  <= '0;
      instr_q <= '0;
      alu_q   <= '0;
      reg2_q  <= '0;
      cero_q  <= 1'b0;
      rd_q    <= '0;
      br_q    <= 1'b0;
      memw_q  <= 1'b0;
      memr_q  <= 1'b0;
      filt_q  <= '0;
      m2r_q   <= 1'b0;
      regw_q  <= 1'b0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      pc4_q   <= pc4_d;
      pcbr_q  <= pcbr_d;
      instr_q <= instr_d;
      alu_q   <= alu_d;
      reg2_q  <= reg2_d;
      cero_q  <= cero_d;
      rd_q    <= rd_d;
      br_q    <= br_d;
      memw_q  <= memw_d;
      memr_q  <= memr_d;
      filt_q  <= filt_d;
      m2r_q   <= m2r_d;
      regw_q  <= regw_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.o_PC4             = pc4_q;
  assign bus.o_PCBranch        = pcbr_q;
  assign bus.o_Instruction     = instr_q;
  assign bus.o_ALU             = alu_q;
  assign bus.o_Registro2       = reg2_q;
  assign bus.o_Cero            = cero_q;
  assign bus.o_RegistroDestino = rd_q;
  assign bus.o_Branch          = br_q;
  assign bus.o_MemWrite        = memw_q;
  assign bus.o_MemRead         = memr_q;
  assign bus.o_TamanoFiltro    = filt_q;
  assign bus.o_MemToReg        = m2r_q;
  assign bus.o_RegWrite        = regw_q;
  assign bus.o_Valid           = valid_q;
  assign bus.o_PCSrc           = br_q & cero_q & valid_q;
  assign bus.o_InstrCount      = cnt_q;

endmodule

// File: tb/tb_etapa_ex_mem_ctl.sv
// Directed + randomised bench for etapa_ex_mem_ctl with a scoreboard of
// expected MEM-stage values built from a behavioural reference.
module tb_etapa_ex_mem_ctl;
  localparam int NBITS = 32;
  localparam int REGS  = 5;
  localparam int FILTW = 2;
  localparam int CNTW  = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  etapa_ex_mem_ctl_if #(.NBITS(NBITS), .REGS(REGS), .FILTW(FILTW), .CNTW(CNTW)) bus ();

  etapa_ex_mem_ctl #(.NBITS(NBITS), .REGS(REGS), .FILTW(FILTW), .CNTW(CNTW)) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .bus       (bus)
  );

  typedef struct packed {
    logic [NBITS-1:0] pc4, pcb, ins, alu, r2;
    logic             cero;
    logic [REGS-1:0]  rd;
    logic             br, mw, mr;
    logic [FILTW-1:0] filt;
    logic             m2r, rw, valid;
    logic [CNTW-1:0]  cnt;
  } exp_t;

  exp_t  m;
  exp_t  sb[$];
  int    n_assert = 0;
  int    n_fail   = 0;
  string tag      = "init";

  task automatic chk(input string f, input logic [NBITS-1:0] obs, input logic [NBITS-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s.%s observed=%0h expected=%0h", tag, f, obs, exp);
    end
  endtask

  task automatic compare();
    exp_t e;
    if (sb.size() == 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL %s.scoreboard observed=empty expected=entry", tag);
    end else begin
      e = sb.pop_front();
      chk("PC4",      bus.o_PC4,             e.pc4);
      chk("PCBranch", bus.o_PCBranch,        e.pcb);
      chk("Instr",    bus.o_Instruction,     e.ins);
      chk("ALU",      bus.o_ALU,             e.alu);
      chk("Reg2",     bus.o_Registro2,       e.r2);
      chk("Cero",     NBITS'(bus.o_Cero),    NBITS'(e.cero));
      chk("RegDst",   NBITS'(bus.o_RegistroDestino), NBITS'(e.rd));
      chk("Branch",   NBITS'(bus.o_Branch),  NBITS'(e.br));
      chk("MemWrite", NBITS'(bus.o_MemWrite), NBITS'(e.mw));
      chk("MemRead",  NBITS'(bus.o_MemRead), NBITS'(e.mr));
      chk("Filtro",   NBITS'(bus.o_TamanoFiltro), NBITS'(e.filt));
      chk("MemToReg", NBITS'(bus.o_MemToReg), NBITS'(e.m2r));
      chk("RegWrite", NBITS'(bus.o_RegWrite), NBITS'(e.rw));
      chk("Valid",    NBITS'(bus.o_Valid),   NBITS'(e.valid));
      chk("PCSrc",    NBITS'(bus.o_PCSrc),   NBITS'(e.br & e.cero & e.valid));
      chk("Count",    NBITS'(bus.o_InstrCount), NBITS'(e.cnt));
    end
  endtask

  // Reference behaviour of one falling edge, evaluated on the current inputs.
  task automatic model_edge();
    logic [CNTW-1:0] c;
    c = m.cnt;
    if (bus.i_Flush) begin
      m = '0;
    end else if (!bus.i_Stall && bus.i_Enable) begin
      m.pc4   = bus.i_PC4;
      m.pcb   = bus.i_PCBranch;
      m.ins   = bus.i_Instruction;
      m.alu   = bus.i_ALU;
      m.r2    = bus.i_Registro2;
      m.cero  = bus.i_Cero;
      m.rd    = bus.i_RegistroDestino;
      m.filt  = bus.i_TamanoFiltro;
      m.valid = bus.i_Valid;
      m.br    = bus.i_Valid ? bus.i_Branch   : 1'b0;
      m.mw    = bus.i_Valid ? bus.i_MemWrite : 1'b0;
      m.mr    = bus.i_Valid ? bus.i_MemRead  : 1'b0;
      m.m2r   = bus.i_Valid ? bus.i_MemToReg : 1'b0;
      m.rw    = bus.i_Valid ? bus.i_RegWrite : 1'b0;
      if (bus.i_Valid) c = c + 1'b1;
    end
    m.cnt = bus.i_ClearCount ? '0 : c;
  endtask

  task automatic step(input string t);
    tag = t;
    model_edge();
    sb.push_back(m);
    @(negedge clk);
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic check_now(input string t);
    tag = t;
    sb.push_back(m);
    compare();
  endtask

  task automatic rand_data();
    bus.i_PC4             = $urandom;
    bus.i_PCBranch        = $urandom;
    bus.i_Instruction     = $urandom;
    bus.i_ALU             = $urandom;
    bus.i_Registro2       = $urandom;
    bus.i_Cero            = 1'($urandom);
    bus.i_RegistroDestino = REGS'($urandom);
    bus.i_TamanoFiltro    = FILTW'($urandom);
    bus.i_Branch          = 1'($urandom);
    bus.i_MemWrite        = 1'($urandom);
    bus.i_MemRead         = 1'($urandom);
    bus.i_MemToReg        = 1'($urandom);
    bus.i_RegWrite        = 1'($urandom);
  endtask

  task automatic zero_data();
    bus.i_PC4 = '0; bus.i_PCBranch = '0; bus.i_Instruction = '0;
    bus.i_ALU = '0; bus.i_Registro2 = '0; bus.i_Cero = 1'b0;
    bus.i_RegistroDestino = '0; bus.i_TamanoFiltro = '0;
    bus.i_Branch = 1'b0; bus.i_MemWrite = 1'b0; bus.i_MemRead = 1'b0;
    bus.i_MemToReg = 1'b0; bus.i_RegWrite = 1'b0;
  endtask

  initial begin
    m = '0;
    bus.i_Enable = 1'b1; bus.i_Stall = 1'b0; bus.i_Flush = 1'b0;
    bus.i_ClearCount = 1'b0; bus.i_Valid = 1'b0;
    zero_data();

    // Power-on reset
    #1 rst_n = 1'b0;
    #2 check_now("reset");
    @(posedge clk); #1 rst_n = 1'b1;

    // Plain load
    bus.i_Valid = 1'b1; bus.i_PC4 = 32'h4; bus.i_ALU = 32'hA;
    bus.i_RegistroDestino = 5'd5; bus.i_RegWrite = 1'b1;
    step("load");

    // Reset mid-run, between edges
    bus.i_ALU = 32'h12345678;
    step("preload");
    #2 rst_n = 1'b0;
    #1 m = '0;
    check_now("reset_mid");
    rst_n = 1'b1;

    bus.i_ALU = 32'hA;
    step("reload");

    // Stall three edges while inputs change
    bus.i_Stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_data();
      step("stall");
    end

    // Flush overrides stall
    bus.i_Flush = 1'b1;
    step("stall_flush");
    bus.i_Flush = 1'b0; bus.i_Stall = 1'b0;

    // Branch taken, then same with bubble
    zero_data();
    bus.i_Branch = 1'b1; bus.i_Cero = 1'b1; bus.i_Valid = 1'b1;
    bus.i_ALU = 32'hB0;
    step("branch_taken");
    bus.i_Valid = 1'b0; bus.i_MemWrite = 1'b1; bus.i_RegWrite = 1'b1;
    bus.i_ALU = 32'hB1;
    step("branch_bubble");

    // Debug step: four held edges, then a single load
    bus.i_Valid = 1'b1;
    bus.i_Enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rand_data();
      step("dbg_hold");
    end
    bus.i_Enable = 1'b1;
    rand_data();
    step("dbg_step");

    // Clear together with a valid load
    bus.i_ClearCount = 1'b1;
    step("clear_load");
    bus.i_ClearCount = 1'b0;

    // Eight valid loads: 1..7 then wrap to 0
    for (int i = 0; i < 8; i++) begin
      rand_data();
      step("wrap");
    end

    // Clear honoured during hold and during flush
    step("count_up");
    bus.i_Stall = 1'b1; bus.i_ClearCount = 1'b1;
    step("clear_hold");
    bus.i_Stall = 1'b0; bus.i_ClearCount = 1'b0;
    step("count_up2");
    bus.i_Flush = 1'b1; bus.i_ClearCount = 1'b1;
    step("clear_flush");
    bus.i_Flush = 1'b0; bus.i_ClearCount = 1'b0;

    // Randomised mix of controls
    for (int i = 0; i < 40; i++) begin
      rand_data();
      bus.i_Valid      = 1'($urandom);
      bus.i_Flush      = ($urandom_range(0, 7) == 0);
      bus.i_Stall      = ($urandom_range(0, 3) == 0);
      bus.i_Enable     = ($urandom_range(0, 3) != 0);
      bus.i_ClearCount = ($urandom_range(0, 7) == 0);
      step("random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/etapa_ex_mem_ctl.md
# etapa_ex_mem_ctl

Parametrised EX/MEM pipeline register with asynchronous active-low reset, debug step enable, stall (hold), flush (bubble insertion), per-slot valid tracking, registered branch decision and a retired-instruction counter for the debug unit. Sits between the EX stage (ALU, branch adder) and the MEM stage (data memory, branch PC mux), and is driven by the hazard unit and the debug unit.

## Interface
Parameters:
- NBITS, 32, datapath width (PC, instruction, ALU result, store data)
- REGS, 5, register-index width
- FILTW, 2, memory access-size filter width
- CNTW, 32, retired-instruction counter width

Ports:
- i_clk  in  1  clock; the register updates on the falling edge, as in every pipeline stage
- i_reset_n  in  1  asynchronous, active-low reset
- i_Enable  in  1  debug step enable; low holds all state
- i_Stall  in  1  hazard hold; high holds all state
- i_Flush  in  1  bubble insertion; overrides stall and enable
- i_ClearCount  in  1  synchronous clear of o_InstrCount
- i_Valid  in  1  EX slot holds a real instruction
- i_PC4, i_PCBranch, i_Instruction, i_ALU, i_Registro2  in  NBITS  EX-stage data
- i_Cero  in  1  ALU zero flag
- i_RegistroDestino  in  REGS  destination register
- i_Branch, i_MemWrite, i_MemRead, i_MemToReg, i_RegWrite  in  1  M/WB control
- i_TamanoFiltro  in  FILTW  access size
- o_PC4, o_PCBranch, o_Instruction, o_ALU, o_Registro2, o_Cero, o_RegistroDestino, o_Branch, o_MemWrite, o_MemRead, o_TamanoFiltro, o_MemToReg, o_RegWrite  out  same widths  registered copies
- o_Valid  out  1  MEM slot holds a real instruction
- o_PCSrc  out  1  branch taken = o_Branch & o_Cero & o_Valid (combinational from registers)
- o_InstrCount  out  CNTW  number of valid instructions loaded

## Operation
- Reset (i_reset_n low, any time): all registered outputs 0, o_Valid 0, o_InstrCount 0, o_PCSrc therefore 0. Takes effect immediately, without waiting for a clock edge.
- Action at each falling edge is chosen by priority: reset > flush > hold > load.
- Flush (i_Flush=1): o_Valid, o_Branch, o_MemWrite, o_MemRead, o_MemToReg and o_RegWrite go to 0. All data fields and o_TamanoFiltro go to 0. The counter does not change. Flush applies even when i_Enable=0 or i_Stall=1.
- Hold (i_Stall=1 or i_Enable=0, no flush): every register keeps its value, including the counter unless i_ClearCount.
- Load (otherwise): all fields take their inputs and o_Valid<=i_Valid.
- Load with i_Valid=0: control bits are forced to 0 regardless of their inputs, so a bubble can never write memory or registers. Data fields still load.
- Counter:
  - Increments by 1 on a load with i_Valid=1.
  - Wraps from 2^CNTW-1 to 0.
  - i_ClearCount sets it to 0 and wins over an increment in the same edge.
  - i_ClearCount is honoured even during hold or flush.

## Timing
- Latency is 1 falling edge from input to output; there is no combinational path from any input to any output.
- o_PCSrc is valid for the half-cycle after the falling edge and feeds the rising-edge IF PC mux.
- Hazard unit rules:
  - i_Stall/i_Flush must be stable before the falling edge.
  - A stall released for one cycle loads exactly once.
- Reset deassertion is synchronised externally. The first load occurs on the first falling edge with i_reset_n high.

## Test plan
- Reset mid-run: load i_ALU=0x12345678, i_RegWrite=1, then pull i_reset_n low between edges -> all outputs 0 immediately; o_InstrCount=0.
- Plain load: i_Valid=1, i_PC4=0x4, i_ALU=0xA, i_RegistroDestino=5, i_RegWrite=1 -> after one falling edge o_PC4=0x4, o_ALU=0xA, o_RegistroDestino=5, o_RegWrite=1, o_Valid=1, o_InstrCount=1.
- Stall then flush: hold i_Stall=1 for 3 edges while inputs change -> outputs frozen and counter frozen. Then assert i_Stall=1 and i_Flush=1 together -> o_Valid=0, all control 0, o_ALU=0.
- Branch: i_Branch=1, i_Cero=1, i_Valid=1 -> o_PCSrc=1 after the edge. Same inputs with i_Valid=0 -> o_PCSrc=0 and o_Branch=0.
- Debug step: i_Enable=0 for 4 edges, then 1 for one edge with i_Valid=1 -> exactly one load; counter increments by 1.
- Counter wrap/clear: CNTW=3, 8 valid loads -> o_InstrCount sequence 1..7, then 0. i_ClearCount together with a valid load -> o_InstrCount=0.
